// File: rtl/pe5x5_ctrl.sv
// pe5x5_ctrl: byte-stream sequencer for a row of NUM_PE processing elements.
// Steers PE_LEN weight bytes and then PE_LEN input-feature bytes into each PE
// using registered one-hot write strobes. It then waits RESULT_LAT cycles for
// the summed row result, captures that result, and offers it on a valid/ready
// output. Loaded weights can be reused, so a new window needs only the IF bytes.
module pe5x5_ctrl #(
  parameter int NUM_PE     = 5,
  parameter int PE_LEN     = 5,
  parameter int RESULT_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              keep_w,
  output logic              busy,
  output logic              done,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [NUM_PE-1:0] pe_w_w,
  output logic [NUM_PE-1:0] pe_if_w,
  output logic [7:0]        w_in,
  output logic [7:0]        if_in,
  input  logic [31:0]       pe_result,
  output logic [31:0]       out_result,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int IDX_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int TAP_W  = (PE_LEN > 1) ? $clog2(PE_LEN) : 1;
  localparam int WAIT_W = (RESULT_LAT > 0) ? $clog2(RESULT_LAT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_IF,
    S_WAIT,
    S_OUT
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_pe_idx;
  logic [TAP_W-1:0]    r_tap;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic                r_w_loaded;
  logic                r_busy;
  logic                r_done;
  logic                r_in_ready;
  logic [NUM_PE-1:0]   r_pe_w_w;
  logic [NUM_PE-1:0]   r_pe_if_w;
  logic [7:0]          r_w_in;
  logic [7:0]          r_if_in;
  logic [31:0]         r_out_result;
  logic                r_out_valid;

  logic                w_xfer;
  logic                w_last_tap;
  logic                w_last_byte;
  logic [NUM_PE-1:0]   w_onehot;

  // A byte moves only while in_ready is high, so transfers are confined to the
  // two load states.
  assign w_xfer      = in_valid && r_in_ready;
  assign w_last_tap  = (r_tap == TAP_W'(PE_LEN - 1));
  assign w_last_byte = w_last_tap && (r_pe_idx == IDX_W'(NUM_PE - 1));
  assign w_onehot    = NUM_PE'(1) << r_pe_idx;

  // Controller FSM with all outputs registered: steering, counters, wait, output handshake.
  // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge
  // state regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_pe_idx     <= '0;
      r_tap        <= '0;
      r_wait_cnt   <= '0;
      r_w_loaded   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_in_ready   <= 1'b0;
      r_pe_w_w     <= '0;
      r_pe_if_w    <= '0;
      r_w_in       <= '0;
      r_if_in      <= '0;
      r_out_result <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      // The strobes default low and rise for one cycle only after a transfer.
      r_pe_w_w  <= '0;
      r_pe_if_w <= '0;
      r_done    <= 1'b0;

      if (w_xfer) begin
        if (r_state == S_LOAD_W) begin
          r_pe_w_w <= w_onehot;
          r_w_in   <= in_data;
        end else begin
          r_pe_if_w <= w_onehot;
          r_if_in   <= in_data;
        end
        if (w_last_tap) begin
          r_tap    <= '0;
          r_pe_idx <= r_pe_idx + 1'b1;
        end else begin
          r_tap <= r_tap + 1'b1;
        end
      end

      // NOTE: a later non-blocking assignment to the same register wins. The
      // phase-end counter clears below therefore override the increment above.
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
            r_pe_idx   <= '0;
            r_tap      <= '0;
            if (keep_w && r_w_loaded) begin
              r_state <= S_LOAD_IF;
            end else begin
              // A fresh weight load invalidates the old set until it completes.
              r_w_loaded <= 1'b0;
              r_state    <= S_LOAD_W;
            end
          end
        end

        S_LOAD_W: begin
          if (w_xfer && w_last_byte) begin
            r_w_loaded <= 1'b1;
            r_pe_idx   <= '0;
            r_tap      <= '0;
            r_state    <= S_LOAD_IF;
          end
        end

        S_LOAD_IF: begin
          if (w_xfer && w_last_byte) begin
            r_pe_idx   <= '0;
            r_tap      <= '0;
            r_in_ready <= 1'b0;
            r_wait_cnt <= WAIT_W'(RESULT_LAT);
            r_state    <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (r_wait_cnt == '0) begin
            r_out_result <= pe_result;
            r_out_valid  <= 1'b1;
            r_state      <= S_OUT;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end

        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign in_ready   = r_in_ready;
  assign pe_w_w     = r_pe_w_w;
  assign pe_if_w    = r_pe_if_w;
  assign w_in       = r_w_in;
  assign if_in      = r_if_in;
  assign out_result = r_out_result;
  assign out_valid  = r_out_valid;

endmodule

// File: tb/tb_pe5x5_ctrl.sv
// Bench for pe5x5_ctrl. A behavioural PE-row model latches the strobed bytes
// and returns their dot product RESULT_LAT cycles after the last IF strobe.
// Expected strobes and results are queued as stimulus is driven. They are
// checked when the DUT produces them.
module tb_pe5x5_ctrl;

  localparam int NUM_PE     = 5;
  localparam int PE_LEN     = 5;
  localparam int RESULT_LAT = 2;
  localparam int NBYTES     = NUM_PE * PE_LEN;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              keep_w = 1'b0;
  logic              busy;
  logic              done;
  logic [7:0]        in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NUM_PE-1:0] pe_w_w;
  logic [NUM_PE-1:0] pe_if_w;
  logic [7:0]        w_in;
  logic [7:0]        if_in;
  logic [31:0]       pe_result = '0;
  logic [31:0]       out_result;
  logic              out_valid;
  logic              out_ready = 1'b0;

  pe5x5_ctrl #(
    .NUM_PE    (NUM_PE),
    .PE_LEN    (PE_LEN),
    .RESULT_LAT(RESULT_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .keep_w    (keep_w),
    .busy      (busy),
    .done      (done),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pe_w_w    (pe_w_w),
    .pe_if_w   (pe_if_w),
    .w_in      (w_in),
    .if_in     (if_in),
    .pe_result (pe_result),
    .out_result(out_result),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_w;
    int         pe;
    logic [7:0] data;
  } strb_t;

  strb_t       exp_strb_q[$];
  logic [31:0] exp_res_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_if_cyc = 0;
  bit force_res   = 1'b0;

  logic [7:0] w_dat [NBYTES];
  logic [7:0] f_dat [NBYTES];

  // PE row model state
  logic [7:0]  mw [NUM_PE][PE_LEN];
  logic [7:0]  mf [NUM_PE][PE_LEN];
  int          wcnt [NUM_PE];
  int          fcnt [NUM_PE];
  logic [31:0] acc;

  initial begin
    for (int p = 0; p < NUM_PE; p++) begin
      wcnt[p] = 0;
      fcnt[p] = 0;
      for (int t = 0; t < PE_LEN; t++) begin
        mw[p][t] = '0;
        mf[p][t] = '0;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // PE row model: pe_result is the dot product of the latched bytes one edge
  // after latching, so it is valid RESULT_LAT cycles after the strobe cycle.
  always @(posedge clk) begin
    acc = '0;
    for (int p = 0; p < NUM_PE; p++)
      for (int t = 0; t < PE_LEN; t++)
        acc = acc + 32'(mw[p][t]) * 32'(mf[p][t]);
    pe_result <= force_res ? 32'hFFFF_FFFF : acc;
    if (!rst) begin
      for (int p = 0; p < NUM_PE; p++) begin
        wcnt[p] <= 0;
        fcnt[p] <= 0;
      end
    end else begin
      for (int p = 0; p < NUM_PE; p++) begin
        if (pe_w_w[p]) begin
          mw[p][wcnt[p] % PE_LEN] <= w_in;
          wcnt[p] <= wcnt[p] + 1;
        end
        if (pe_if_w[p]) begin
          mf[p][fcnt[p] % PE_LEN] <= if_in;
          fcnt[p] <= fcnt[p] + 1;
        end
      end
    end
  end

  // Strobe scoreboard: every observed strobe must match the next queued byte.
  always @(negedge clk) begin
    strb_t             e;
    logic [NUM_PE-1:0] ew;
    logic [NUM_PE-1:0] ef;
    logic [7:0]        ed;
    if (rst && (pe_w_w !== '0 || pe_if_w !== '0)) begin
      vectors++;
      if (pe_if_w !== '0) last_if_cyc = cyc;
      if (exp_strb_q.size() == 0) begin
        miscompares++;
        $display("FAIL strobe_unexpected: got w=%b if=%b, required no strobe", pe_w_w, pe_if_w);
      end else begin
        e  = exp_strb_q.pop_front();
        ew = e.is_w ? (NUM_PE'(1) << e.pe) : '0;
        ef = e.is_w ? '0 : (NUM_PE'(1) << e.pe);
        ed = e.is_w ? w_in : if_in;
        if (pe_w_w !== ew || pe_if_w !== ef || ed !== e.data) begin
          miscompares++;
          $display("FAIL strobe_seq: got w=%b if=%b data=%h, required w=%b if=%b data=%h",
                   pe_w_w, pe_if_w, ed, ew, ef, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] dot_ref();
    logic [31:0] s = '0;
    for (int i = 0; i < NBYTES; i++) s = s + 32'(w_dat[i]) * 32'(f_dat[i]);
    return s;
  endfunction

  // Pulse start for one cycle; entered and left on a falling edge.
  task automatic start_op(input bit keep);
    start  = 1'b1;
    keep_w = keep;
    @(negedge clk);
    start  = 1'b0;
    keep_w = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_start: got %b, required 1", busy);
    end
  endtask

  // Stream count bytes; gap=1 uses the in_valid pattern 1,0,0.
  task automatic send_bytes(input bit is_w, input bit gap, input int count);
    int    n = 0;
    int    k = 0;
    bit    v;
    strb_t e;
    while (n < count && k < 400) begin
      v        = gap ? (k % 3 == 0) : 1'b1;
      in_valid = v;
      in_data  = v ? (is_w ? w_dat[n] : f_dat[n]) : 8'hA5;
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL in_ready_load: got %b, required 1 (byte %0d)", in_ready, n);
      end
      if (v && in_ready === 1'b1) begin
        e.is_w = is_w;
        e.pe   = n / PE_LEN;
        e.data = is_w ? w_dat[n] : f_dat[n];
        exp_strb_q.push_back(e);
        n++;
      end
      k++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (n < count) begin
      miscompares++;
      $display("FAIL send_timeout: got %0d bytes, required %0d", n, count);
    end
  endtask

  // Wait for the result, optionally stall the handshake, then check done and busy.
  task automatic finish_op(input int stall, input bit pulse_start);
    int          k = 0;
    logic [31:0] held;
    logic [31:0] exp;
    out_ready = (stall == 0);
    while (out_valid !== 1'b1 && k < 20) begin
      vectors++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL wait_state: got in_ready=%b busy=%b, required 0/1", in_ready, busy);
      end
      @(negedge clk);
      k++;
    end
    if (k == 20) begin
      miscompares++;
      $display("FAIL out_valid_timeout: got no out_valid, required within 20 cycles");
      exp_res_q.delete();
      out_ready = 1'b0;
      return;
    end
    vectors++;
    if (cyc - last_if_cyc !== RESULT_LAT + 1) begin
      miscompares++;
      $display("FAIL result_latency: got %0d cycles, required %0d", cyc - last_if_cyc, RESULT_LAT + 1);
    end
    vectors++;
    if (exp_strb_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_strobes: got %0d outstanding, required 0", exp_strb_q.size());
      exp_strb_q.delete();
    end
    held = out_result;
    for (int i = 0; i < stall; i++) begin
      start = pulse_start && (i % 3 == 0);
      vectors++;
      if (out_valid !== 1'b1 || out_result !== held || done !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL out_stall: got valid=%b result=%h done=%b busy=%b, required 1/%h/0/1",
                 out_valid, out_result, done, busy, held);
      end
      @(negedge clk);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    exp       = exp_res_q.pop_front();
    vectors++;
    if (out_valid !== 1'b1 || out_result !== exp) begin
      miscompares++;
      $display("FAIL out_result: got valid=%b result=%h, required 1/%h", out_valid, out_result, exp);
    end
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse: got done=%b busy=%b valid=%b, required 1/0/0", done, busy, out_valid);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_done: got done=%b busy=%b in_ready=%b, required 0/0/0", done, busy, in_ready);
    end
  endtask

  task automatic run_op(input bit keep, input bit load_w, input bit gap,
                        input int stall, input bit pulse_start);
    exp_res_q.push_back(force_res ? 32'hFFFF_FFFF : dot_ref());
    start_op(keep);
    if (load_w) send_bytes(1'b1, gap, NBYTES);
    send_bytes(1'b0, gap, NBYTES);
    finish_op(stall, pulse_start);
  endtask

  task automatic check_all_zero(input string name);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || pe_w_w !== '0 || pe_if_w !== '0 ||
        w_in !== '0 || if_in !== '0 || out_result !== '0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got busy=%b done=%b rdy=%b w=%b if=%b win=%h ifin=%h res=%h vld=%b, required all 0",
               name, busy, done, in_ready, pe_w_w, pe_if_w, w_in, if_in, out_result, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    check_all_zero("reset_outputs");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_basic();
    for (int i = 0; i < NBYTES; i++) begin
      w_dat[i] = 8'd1;
      f_dat[i] = 8'(i + 1);
    end
    run_op(1'b0, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_input_gaps();
    run_op(1'b0, 1'b1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_keep_w();
    for (int i = 0; i < NBYTES; i++) f_dat[i] = 8'd2;
    run_op(1'b1, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_out_stall();
    for (int i = 0; i < NBYTES; i++) f_dat[i] = 8'(i + 1);
    run_op(1'b1, 1'b0, 1'b0, 10, 1'b1);
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < NBYTES; i++) w_dat[i] = 8'd3;
    start_op(1'b0);
    send_bytes(1'b1, 1'b0, 12);
    #2;
    rst = 1'b0;
    #1;
    exp_strb_q.delete();
    check_all_zero("reset_mid_load");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // keep_w is requested, but the cleared w_loaded flag forces a full weight load.
    run_op(1'b1, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_max_result();
    force_res = 1'b1;
    run_op(1'b1, 1'b0, 1'b0, 0, 1'b0);
    force_res = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < NBYTES; i++) begin
      w_dat[i] = 8'(i % 7);
      f_dat[i] = 8'(200 + i);
    end
    run_op(1'b0, 1'b1, 1'b0, 0, 1'b0);
    run_op(1'b1, 1'b0, 1'b1, 3, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_input_gaps();
    test_keep_w();
    test_out_stall();
    test_reset_mid_load();
    test_max_result();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
